// File: rtl/uart_digit_pkg.sv
// uart_digit_pkg
//   Definitions shared by the serial digit receiver and its synchronizer:
//   the receiver state encoding, the ASCII bounds of an accepted digit,
//   and the digit value shown after reset.
package uart_digit_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  // Not a legal decimal digit, so a downstream comparator never matches it.
  localparam logic [3:0] DIGIT_IDLE = 4'hF;

endpackage

// File: rtl/uart_digit_rx_sync.sv
// uart_digit_rx_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops
//   reset to 1 (line idle), so leaving reset cannot look like a start bit.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   rx      in   raw serial line, idle high
//   rx_sync out  rx delayed by two clk cycles, safe to sample
module uart_digit_rx_sync
  import uart_digit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync
);

  logic rx_p0;
  logic rx_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      // stage p0: first capture, may go metastable
      rx_p0 <= rx;
      // stage p1: settled copy
      rx_p1 <= rx_p0;
    end
  end

  assign rx_sync = rx_p1;

endmodule

// File: rtl/uart_digit_receiver.sv
// uart_digit_receiver
//   Receives ASCII characters from an 8N1 serial link and converts '0'..'9'
//   into a 4-bit digit. A digit update is marked by a one-cycle digit_valid
//   strobe. Non-digit bytes pulse char_err. A low stop bit pulses frame_err,
//   after which the line must stay high for a full bit before the next frame.
//   Define UART_DIGIT_PARITY_EN to expect an even-parity bit after the data;
//   a parity mismatch then also pulses frame_err.
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (8..65535)
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   rx           in   asynchronous serial line, idle high
//   digit        out  last accepted digit, 4'hF after reset
//   digit_valid  out  one-cycle strobe, digit updated
//   frame_err    out  one-cycle strobe, bad stop bit or parity
//   char_err     out  one-cycle strobe, well-formed non-digit byte
//   busy         out  high from start-bit detection until back in IDLE
module uart_digit_receiver
  import uart_digit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       frame_err,
  output logic       char_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // The first load lands the start-bit sample mid-bit; all later loads
  // step one whole bit, keeping every sample mid-bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_s;
  logic             expired;
  logic             par_ok;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  uart_digit_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_sync (rx_s)
  );

  assign expired = (cnt == '0);

  // Data capture: only the shift register (and parity bit) live here; they
  // are never read before being fully rewritten, so they carry no reset.
`ifdef UART_DIGIT_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (state == DATA && expired) shreg <= {rx_s, shreg[7:1]};
    if (state == PARITY && expired) par_bit <= rx_s;
  end

  // Even parity: data plus parity bit must hold an even number of ones.
  assign par_ok = ~(^{shreg, par_bit});
`else
  always_ff @(posedge clk) begin
    if (state == DATA && expired) shreg <= {rx_s, shreg[7:1]};
  end

  assign par_ok = 1'b1;
`endif

  // Control: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      digit       <= DIGIT_IDLE;
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      char_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      char_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= HALF_LOAD;
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (expired) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= FULL_LOAD;
            end else begin
              // Line was high again at mid-bit: a glitch, not a start bit.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (expired) begin
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_DIGIT_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef UART_DIGIT_PARITY_EN
        PARITY: begin
          if (expired) begin
            cnt   <= FULL_LOAD;
            state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        STOP: begin
          if (expired) begin
            if (rx_s && par_ok) begin
              // Back to IDLE half a bit early so an immediately following
              // start edge is not missed.
              state <= IDLE;
              busy  <= 1'b0;
              if (is_digit(shreg)) begin
                digit       <= shreg[3:0];
                digit_valid <= 1'b1;
              end else begin
                char_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= RECOVER;
              cnt       <= FULL_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RECOVER: begin
          // Any low sample restarts the one-bit high-time requirement, so a
          // held break keeps the block here.
          if (!rx_s) begin
            cnt <= FULL_LOAD;
          end else if (expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_digit_receiver.sv
module tb_uart_digit_receiver;
  import uart_digit_pkg::*;

  localparam int C = 16;
`ifdef UART_DIGIT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Start-bit fall (driven just after an edge) to first digit_valid cycle:
  // 3 sync/detect cycles + half bit + remaining bits up to the stop sample.
  localparam int LAT = 3 + C / 2 + (NB - 1) * C;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [3:0] digit;
  logic       digit_valid;
  logic       frame_err;
  logic       char_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0, nframe = 0, nchar = 0, nmulti = 0;
  int last_valid_cyc = 0;
  int dq[$];
  int t0, v0, f0, c0;

  uart_digit_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .digit       (digit),
    .digit_valid (digit_valid),
    .frame_err   (frame_err),
    .char_err    (char_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (digit_valid) begin
      nvalid++;
      dq.push_back(int'(digit));
      last_valid_cyc = cyc;
    end
    if (frame_err) nframe++;
    if (char_err) nchar++;
    if (int'(digit_valid) + int'(frame_err) + int'(char_err) > 1) nmulti++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives bits[0..n-1], each held C cycles; called and returns at edge+1.
  task automatic shift_out(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
`ifdef UART_DIGIT_PARITY_EN
    shift_out({stop_v, ^b, b, 1'b0}, 11);
`else
    shift_out({1'b1, stop_v, b, 1'b0}, 10);
`endif
  endtask

`ifdef UART_DIGIT_PARITY_EN
  task automatic send_badpar(input logic [7:0] b);
    shift_out({1'b1, ~(^b), b, 1'b0}, 11);
  endtask
`endif

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_char_err", 32'(char_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5);

    // Single '1' with exact strobe timing and width
    t0 = cyc;
    v0 = nvalid;
    send(8'h31, 1'b1);
    check("one_count", 32'(nvalid - v0), 32'd1);
    check("one_latency", 32'(last_valid_cyc - t0), 32'(LAT));
    check("one_digit", 32'(digit), 32'd1);
    check("one_busy_low", 32'(busy), 32'd0);

    // Back-to-back '1','0','9','4', no idle gap
    dq.delete();
    v0 = nvalid; f0 = nframe; c0 = nchar;
    send(8'h31, 1'b1);
    send(8'h30, 1'b1);
    send(8'h39, 1'b1);
    send(8'h34, 1'b1);
    check("b2b_count", 32'(nvalid - v0), 32'd4);
    check("b2b_d0", 32'(dq[0]), 32'd1);
    check("b2b_d1", 32'(dq[1]), 32'd0);
    check("b2b_d2", 32'(dq[2]), 32'd9);
    check("b2b_d3", 32'(dq[3]), 32'd4);
    check("b2b_no_err", 32'((nframe - f0) + (nchar - c0)), 32'd0);
    idle(3 * C);
    check("b2b_hold", 32'(digit), 32'd4);

    // 'A' is not a digit
    v0 = nvalid; c0 = nchar;
    send(8'h41, 1'b1);
    check("A_char_err", 32'(nchar - c0), 32'd1);
    check("A_no_valid", 32'(nvalid - v0), 32'd0);
    check("A_digit_kept", 32'(digit), 32'd4);

    // '5' with low stop bit, line held low, then released
    f0 = nframe; v0 = nvalid;
    send(8'h35, 1'b0);
    idle(3 * C);
    check("stop_frame_err", 32'(nframe - f0), 32'd1);
    check("stop_no_valid", 32'(nvalid - v0), 32'd0);
    check("stop_digit_kept", 32'(digit), 32'd4);
    check("recover_busy_low_line", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(C / 2);
    check("recover_busy_half", 32'(busy), 32'd1);
    idle(2 * C);
    check("recover_done", 32'(busy), 32'd0);
    send(8'h37, 1'b1);
    check("after_recover_digit", 32'(digit), 32'd7);

    // Start glitch of C/4 cycles
    v0 = nvalid; f0 = nframe; c0 = nchar;
    rx = 1'b0;
    idle(C / 4);
    rx = 1'b1;
    check("glitch_busy_rise", 32'(busy), 32'd1);
    idle(C);
    check("glitch_busy_fall", 32'(busy), 32'd0);
    check("glitch_no_strobe", 32'((nvalid - v0) + (nframe - f0) + (nchar - c0)), 32'd0);
    send(8'h33, 1'b1);
    check("glitch_next_digit", 32'(digit), 32'd3);

    // Reset in the middle of the data bits of '8' (0x38: LSB-first 0,0,0)
    v0 = nvalid; f0 = nframe; c0 = nchar;
    shift_out(11'b000_0000_0000, 4);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_digit", 32'(digit), 32'hF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_strobes", 32'({digit_valid, frame_err, char_err}), 32'd0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2 * C);
    check("midrst_no_strobe", 32'((nvalid - v0) + (nframe - f0) + (nchar - c0)), 32'd0);
    send(8'h32, 1'b1);
    check("midrst_next_digit", 32'(digit), 32'd2);

`ifdef UART_DIGIT_PARITY_EN
    // '3' with the parity bit inverted
    f0 = nframe; v0 = nvalid;
    send_badpar(8'h33);
    check("par_frame_err", 32'(nframe - f0), 32'd1);
    check("par_no_valid", 32'(nvalid - v0), 32'd0);
    check("par_digit_kept", 32'(digit), 32'd2);
    idle(2 * C);
    check("par_busy_low", 32'(busy), 32'd0);
`endif

    check("one_strobe_per_cycle", 32'(nmulti), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_digit_receiver.md
# uart_digit_receiver

Receives 8N1 ASCII characters (optionally with even parity) on a serial line. It converts the characters '0'–'9' to a 4-bit binary digit and presents each digit for one cycle with a valid strobe. It sits directly upstream of the sequence detector and drives that block's 4-bit digit input from a host serial link. Non-digit characters and malformed frames are reported through error strobes and never produce a digit.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- digit  output  4  last accepted digit value 0..9. Reset value 4'hF, which never matches a digit.
- digit_valid  output  1  one-cycle strobe: digit was updated this cycle. Reset 0.
- frame_err  output  1  one-cycle strobe: stop bit sampled low (or parity mismatch when enabled). Reset 0.
- char_err  output  1  one-cycle strobe: well-formed frame whose byte is outside 8'h30..8'h39. Reset 0.
- busy  output  1  high from start-bit detection until return to IDLE. Reset 0.

## Operation
- rx passes through a 2-flop synchronizer; the synchronizer resets to 1. All decisions use the synchronized value.
- State machine states: IDLE, START, DATA, PARITY (only when compiled in), STOP, RECOVER.
- IDLE: a low synchronized rx moves the block to START and clears the bit counter. The baud counter loads CLKS_PER_BIT/2 − 1, so sampling lands mid-bit.
- START: at counter expiry, re-sample rx.
  - Low: go to DATA and reload the baud counter with CLKS_PER_BIT − 1.
  - High: glitch. Return to IDLE with no strobe.
- DATA: sample 8 bits LSB-first, one per expiry, into the shift register. After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP: sample rx at expiry.
  - Sample 1, parity OK, byte in 0x30..0x39: digit <= byte[3:0] and pulse digit_valid. Return to IDLE.
  - Sample 1, parity OK, byte outside that range: pulse char_err, digit unchanged. Return to IDLE.
  - Sample 0, or parity bad: pulse frame_err. Go to RECOVER.
- RECOVER: wait until synchronized rx is high for one full bit time (break / line-fault tolerance), then IDLE.
- Baud counter width: clog2(CLKS_PER_BIT). The counter counts down; its expiry is count == 0.
- At most one of digit_valid, frame_err, char_err is high in any cycle.
- Asynchronous rst mid-frame aborts the frame: all outputs return to reset values and the state returns to IDLE. The partial byte is discarded.

## Timing
- Strobe latency: each strobe is asserted on the cycle after the stop-bit sample and lasts exactly one cycle.
- Frame-end to valid: digit_valid rises 3 cycles after the stop-bit midpoint on the raw rx pin (2 synchronizer cycles + 1).
- Digit hold: digit holds its value indefinitely between strobes. The downstream stage samples it on every clock, so updates occur only on the digit_valid cycle.
- Back-to-back frames: the block re-arms in IDLE half a bit before the nominal stop-bit end. A start edge arriving immediately after the stop bit is caught.
- busy falls in the same cycle the block re-enters IDLE.

## Configuration
- UART_DIGIT_PARITY_EN defined:
  - A PARITY state follows DATA and samples a ninth bit.
  - Even parity over data + parity bit must be 0; otherwise frame_err pulses at the stop-bit decision and digit is unchanged.
- UART_DIGIT_PARITY_EN undefined: 8N1 format; no PARITY state or logic exists.

## Structure
- Shared package uart_digit_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, RECOVER).
  - ASCII_ZERO = 8'h30, ASCII_NINE = 8'h39.
  - DIGIT_IDLE = 4'hF.
- Sub-module uart_digit_rx_sync: 2-flop synchronizer with reset-to-1. The top instantiates it once.

## Test plan
- Frame 0x31 ('1'), CLKS_PER_BIT=16 → digit=1, digit_valid high for exactly 1 cycle; the strobe timing matches the Timing section.
- Back-to-back '1','0','9','4' with no idle gap → four strobes with digits 1, 0, 9, 4; no errors; digit holds 4 until the next frame.
- Frame 0x41 ('A') → char_err for 1 cycle; digit stays at its previous value; digit_valid stays 0.
- Stop bit forced low on '5' → frame_err pulse; rx held low 3 bit times then released → block stays in RECOVER until one high bit time passes, then the next '7' yields digit=7.
- Start glitch: rx low for CLKS_PER_BIT/4 cycles → no strobe, busy returns low, next valid frame decodes correctly.
- rst asserted mid-DATA of '8' → outputs immediately return to digit=4'hF, busy=0, no strobes; a subsequent '2' yields digit=2. With UART_DIGIT_PARITY_EN, additionally: '3' with wrong parity → frame_err, digit unchanged.
